// File: rtl/gfx_sdr_responder.sv
`default_nettype none
// ============================================================================
// Module  : gfx_sdr_responder
// Purpose : Round-robin SDRAM read arbiter for tile/sprite ROM clients.
//           Each client posts a one-cycle request with an address. One read
//           is outstanding at a time. Read data comes back on a shared data
//           bus, together with a one-cycle ready pulse to the owning client.
// Revision: 1.0 - initial release
// ============================================================================
module gfx_sdr_responder #(
    parameter int NCLIENTS = 4,
    parameter int AW       = 25,
    parameter int DW       = 16
) (
    input  logic                   clk_ram,
    input  logic                   RESET,
    input  logic [NCLIENTS-1:0]    cl_req,
    input  logic [NCLIENTS*AW-1:0] cl_addr,
    output logic [NCLIENTS-1:0]    cl_rdy,
    output logic [DW-1:0]          cl_data,
    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rd,
    input  logic                   mem_ack,
    input  logic                   mem_valid,
    input  logic [DW-1:0]          mem_dout
);

    localparam int OW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // The last owner starts at the highest index so the first search begins at client 0
    localparam logic [OW-1:0] LAST_RST = OW'(NCLIENTS - 1);

    logic [1:0]          state_q,    state_d;
    logic [NCLIENTS-1:0] pending_q,  pending_d;
    logic [AW-1:0]       latch_q [NCLIENTS];
    logic [OW-1:0]       owner_q,    owner_d;
    logic [OW-1:0]       last_q,     last_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [NCLIENTS-1:0] rdy_q,      rdy_d;
    logic [DW-1:0]       data_q,     data_d;

    logic                gnt_found;
    logic [OW-1:0]       gnt_idx;
    int                  cand_int;
    logic [OW-1:0]       cand;

    // Round-robin search: first pending client after the last owner, wrapping around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_int  = 0;
        cand      = '0;
        for (int k = 1; k <= NCLIENTS; k++) begin
            cand_int = (int'(last_q) + k) % NCLIENTS;
            cand     = OW'(cand_int);
            if (!gnt_found && pending_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Next-state logic for the IDLE/ISSUE/WAIT read sequencer and pending flags
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        owner_d    = owner_q;
        last_d     = last_q;
        mem_addr_d = mem_addr_q;
        rdy_d      = '0;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    pending_d[gnt_idx] = 1'b0;
                    owner_d            = gnt_idx;
                    last_d             = gnt_idx;
                    mem_addr_d         = latch_q[gnt_idx];
                    state_d            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A mem_valid coincident with the ack is not data for this read
                if (mem_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    data_d         = mem_dout;
                    rdy_d[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A fresh request re-arms the flag even in the cycle its client is granted
        pending_d = pending_d | cl_req;
    end

    // State, flag and address-latch registers
    always_ff @(posedge clk_ram or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            owner_q    <= '0;
            last_q     <= LAST_RST;
            mem_addr_q <= '0;
            rdy_q      <= '0;
            data_q     <= '0;
            for (int i = 0; i < NCLIENTS; i++) begin
                latch_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            mem_addr_q <= mem_addr_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            for (int i = 0; i < NCLIENTS; i++) begin
                if (cl_req[i]) begin
                    latch_q[i] <= cl_addr[i*AW +: AW];
                end
            end
        end
    end

    assign mem_rd   = (state_q == ST_ISSUE);
    assign mem_addr = mem_addr_q;
    assign cl_rdy   = rdy_q;
    assign cl_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_sdr_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_gfx_sdr_responder
// Purpose : Scoreboard bench for gfx_sdr_responder. Stimulus pushes expected
//           read addresses and client responses; an SDRAM model checks the
//           addresses and a monitor checks every cl_rdy pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gfx_sdr_responder;

    localparam int NC = 4;
    localparam int AW = 25;
    localparam int DW = 16;

    typedef struct packed {
        logic [NC-1:0] rdy;
        logic [DW-1:0] data;
    } rsp_t;

    logic             clk_ram = 1'b0;
    logic             RESET;
    logic [NC-1:0]    cl_req;
    logic [NC*AW-1:0] cl_addr;
    logic [NC-1:0]    cl_rdy;
    logic [DW-1:0]    cl_data;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd;
    logic             mem_ack;
    logic             mem_valid;
    logic [DW-1:0]    mem_dout;

    // SDRAM model drives a_*, directed stimulus drives m_*
    logic             a_ack   = 1'b0;
    logic             a_valid = 1'b0;
    logic [DW-1:0]    a_dout  = '0;
    logic             m_ack   = 1'b0;
    logic             m_valid = 1'b0;
    logic [DW-1:0]    m_dout  = '0;

    assign mem_ack   = a_ack | m_ack;
    assign mem_valid = a_valid | m_valid;
    assign mem_dout  = a_valid ? a_dout : m_dout;

    rsp_t          exp_rsp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            checks = 0;
    int            errors = 0;
    int            ack_dly = 0;
    int            valid_dly = 0;
    bit            mem_auto = 1'b1;
    bit            spurious = 1'b0;

    rsp_t          mon_e;
    logic [AW-1:0] mp_first;
    logic [AW-1:0] mp_addr;
    logic [AW-1:0] mp_exp;

    always #5 clk_ram = ~clk_ram;

    gfx_sdr_responder #(
        .NCLIENTS (NC),
        .AW       (AW),
        .DW       (DW)
    ) u_dut (
        .clk_ram   (clk_ram),
        .RESET     (RESET),
        .cl_req    (cl_req),
        .cl_addr   (cl_addr),
        .cl_rdy    (cl_rdy),
        .cl_data   (cl_data),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_dout  (mem_dout)
    );

    // SDRAM contents: one fixed word for the single-request case, a pattern elsewhere
    function automatic logic [DW-1:0] memdata(input logic [AW-1:0] a);
        if (a == 25'h0012340) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic expect_read(input logic [AW-1:0] a, input logic [NC-1:0] r, input logic [DW-1:0] d);
        rsp_t e;
        e.rdy  = r;
        e.data = d;
        exp_addr_q.push_back(a);
        exp_rsp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_ram);
            #1;
        end
    endtask

    task automatic pulse(input int c, input logic [AW-1:0] a);
        cl_req             = NC'(1) << c;
        cl_addr[c*AW +: AW] = a;
        idle(1);
        cl_req = '0;
    endtask

    task automatic reset_dut();
        RESET  = 1'b1;
        cl_req = '0;
        idle(2);
        RESET = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_rsp_q.size() != 0) && n < budget) begin
            idle(1);
            n++;
        end
        chk("drain_left", 32'(exp_addr_q.size() + exp_rsp_q.size()), 32'd0);
        idle(3);
    endtask

    // Monitor: every ready pulse must match the oldest expected response
    initial begin
        forever begin
            @(negedge clk_ram);
            if (cl_rdy !== '0) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy actual=%b data=%h required=none", cl_rdy, cl_data);
                end else begin
                    mon_e = exp_rsp_q.pop_front();
                    chk("cl_rdy", 32'(cl_rdy), 32'(mon_e.rdy));
                    chk("cl_data", 32'(cl_data), 32'(mon_e.data));
                end
            end
        end
    end

    // SDRAM model: acks after ack_dly cycles, returns data valid_dly cycles later
    initial begin
        forever begin
            @(posedge clk_ram);
            #1;
            if (mem_auto && mem_rd) begin
                mp_first = mem_addr;
                repeat (ack_dly) begin
                    @(posedge clk_ram);
                    #1;
                end
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read actual=%h required=none", mem_addr);
                end else begin
                    mp_exp = exp_addr_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(mp_exp));
                    chk("mem_addr_stable", 32'(mem_addr), 32'(mp_first));
                end
                chk("mem_rd_at_ack", 32'(mem_rd), 32'd1);
                mp_addr = mem_addr;
                a_ack   = 1'b1;
                if (spurious) begin
                    a_valid = 1'b1;
                    a_dout  = 16'hDEAD;
                end
                @(posedge clk_ram);
                #1;
                a_ack   = 1'b0;
                a_valid = 1'b0;
                chk("mem_rd_after_ack", 32'(mem_rd), 32'd0);
                repeat (valid_dly) begin
                    @(posedge clk_ram);
                    #1;
                end
                a_dout  = memdata(mp_addr);
                a_valid = 1'b1;
                @(posedge clk_ram);
                #1;
                a_valid = 1'b0;
                a_dout  = '0;
                chk("rdy_latency", 32'(|cl_rdy), 32'd1);
            end
        end
    end

    // Directed stimulus
    initial begin
        RESET   = 1'b1;
        cl_req  = '0;
        cl_addr = '0;

        // Reset values, requests during reset are dropped, stray ack/valid in IDLE ignored
        cl_req  = '1;
        cl_addr = {25'h44, 25'h33, 25'h22, 25'h11};
        idle(2);
        chk("rst_cl_rdy", 32'(cl_rdy), 32'd0);
        chk("rst_cl_data", 32'(cl_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        cl_req = '0;
        idle(1);
        RESET = 1'b0;
        idle(1);
        m_ack   = 1'b1;
        m_valid = 1'b1;
        m_dout  = 16'h7777;
        idle(1);
        m_ack   = 1'b0;
        m_valid = 1'b0;
        idle(4);
        chk("idle_mem_rd", 32'(mem_rd), 32'd0);
        chk("idle_cl_data", 32'(cl_data), 32'd0);

        // Single request with slow ack and slow data
        reset_dut();
        ack_dly   = 3;
        valid_dly = 5;
        expect_read(25'h0012340, 4'b0100, 16'hBEEF);
        pulse(2, 25'h0012340);
        drain(100);
        chk("hold_cl_data", 32'(cl_data), 32'h0000BEEF);
        ack_dly   = 0;
        valid_dly = 0;

        // All four clients at once, with a valid coincident with every ack
        reset_dut();
        spurious = 1'b1;
        expect_read(25'h10, 4'b0001, 16'h5A4A);
        expect_read(25'h20, 4'b0010, 16'h5A7A);
        expect_read(25'h30, 4'b0100, 16'h5A6A);
        expect_read(25'h40, 4'b1000, 16'h5A1A);
        cl_addr = {25'h40, 25'h30, 25'h20, 25'h10};
        cl_req  = 4'b1111;
        idle(1);
        cl_req = '0;
        drain(200);
        spurious = 1'b0;

        // Fairness: client 3 served before client 0's re-request
        reset_dut();
        expect_read(25'h500, 4'b0001, 16'h5F5A);
        expect_read(25'h530, 4'b1000, 16'h5F6A);
        expect_read(25'h508, 4'b0001, 16'h5F52);
        pulse(0, 25'h500);
        idle(1);
        pulse(3, 25'h530);
        idle(1);
        pulse(0, 25'h508);
        drain(200);
        // Last owner is now 0, so client 1 wins over client 0
        expect_read(25'h550, 4'b0010, 16'h5F0A);
        expect_read(25'h540, 4'b0001, 16'h5F1A);
        cl_addr[0*AW +: AW] = 25'h540;
        cl_addr[1*AW +: AW] = 25'h550;
        cl_req = 4'b0011;
        idle(1);
        cl_req = '0;
        drain(200);

        // Overwrite: two requests from client 1 while client 0 waits for data
        reset_dut();
        valid_dly = 4;
        expect_read(25'h080, 4'b0001, 16'h5ADA);
        expect_read(25'h200, 4'b0010, 16'h585A);
        pulse(0, 25'h080);
        idle(3);
        pulse(1, 25'h100);
        pulse(1, 25'h200);
        drain(200);
        valid_dly = 0;

        // Same-cycle regrant: new request lands in the grant cycle
        reset_dut();
        expect_read(25'h280, 4'b0001, 16'h58DA);
        expect_read(25'h300, 4'b0001, 16'h595A);
        pulse(0, 25'h280);
        pulse(0, 25'h300);
        drain(200);

        // Reset mid-WAIT, late mem_valid ignored, next request served
        reset_dut();
        mem_auto = 1'b0;
        pulse(2, 25'h700);
        idle(1);
        chk("t_rst_mem_rd", 32'(mem_rd), 32'd1);
        chk("t_rst_mem_addr", 32'(mem_addr), 32'h700);
        m_ack = 1'b1;
        idle(1);
        m_ack = 1'b0;
        chk("t_rst_wait_rd", 32'(mem_rd), 32'd0);
        RESET = 1'b1;
        #1;
        chk("t_rst_cl_rdy", 32'(cl_rdy), 32'd0);
        chk("t_rst_mem_addr0", 32'(mem_addr), 32'd0);
        chk("t_rst_mem_rd0", 32'(mem_rd), 32'd0);
        idle(1);
        RESET = 1'b0;
        idle(1);
        m_valid = 1'b1;
        m_dout  = 16'h1234;
        idle(1);
        m_valid = 1'b0;
        m_dout  = '0;
        idle(3);
        chk("t_rst_cl_data", 32'(cl_data), 32'd0);
        chk("t_rst_mem_rd1", 32'(mem_rd), 32'd0);
        mem_auto = 1'b1;
        expect_read(25'h708, 4'b0100, 16'h5D52);
        pulse(2, 25'h708);
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gfx_sdr_responder.md
GFX_SDR_RESPONDER -- requirements
Module: gfx_sdr_responder

Interface
REQ-001 Parameter NCLIENTS, default 4: number of tile/sprite ROM clients served.
REQ-002 Parameter AW, default 25: SDRAM byte-address width.
REQ-003 Parameter DW, default 16: ROM data word width.
REQ-004 clk_ram  in  1  the only clock; all state is updated on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 cl_req  in  NCLIENTS  one-cycle request pulse per client (the client's sdr_req).
REQ-007 cl_addr  in  NCLIENTS*AW  flattened per-client address; client i occupies bits [i*AW +: AW]; sampled only when cl_req[i]=1.
REQ-008 cl_rdy  out  NCLIENTS  one-cycle data-valid pulse per client (the client's sdr_rdy).
REQ-009 cl_data  out  DW  shared return data; valid only in the cycle that any cl_rdy bit is 1.
REQ-010 mem_addr  out  AW  address presented to the SDRAM controller.
REQ-011 mem_rd  out  1  read request level; held until accepted.
REQ-012 mem_ack  in  1  one-cycle pulse: controller accepted mem_addr.
REQ-013 mem_valid  in  1  one-cycle pulse: mem_dout holds read data.
REQ-014 mem_dout  in  DW  SDRAM read data.

Function
REQ-015 Each client SHALL have a pending flag and an AW-bit address latch; cl_req[i]=1 sets pending[i] and loads the latch from cl_addr[i].
REQ-016 A cl_req[i] while pending[i]=1 and not yet granted SHALL overwrite the latch (latest address wins); exactly one read is issued for it.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, WAIT; exactly one read is outstanding at any time.
REQ-018 IDLE: if any pending bit is set, grant one client by round-robin, load mem_addr from its latch, clear its pending flag, record it as owner, go to ISSUE next cycle; else stay in IDLE.
REQ-019 Round-robin: search starts at (last_owner+1) mod NCLIENTS and wraps; last_owner resets to NCLIENTS-1 so that client 0 wins first.
REQ-020 ISSUE: mem_rd=1 and mem_addr held stable; on mem_ack=1 go to WAIT with mem_rd=0 in the next cycle.
REQ-021 WAIT: on mem_valid=1, register mem_dout into cl_data and pulse cl_rdy[owner] for exactly one cycle on the following edge (latency 1 clk_ram from mem_valid); return to IDLE in the same edge.
REQ-022 mem_rd SHALL be 0 in IDLE and WAIT; cl_rdy SHALL be all zero except for the REQ-021 pulse.
REQ-023 cl_req[i] in the same cycle that client i is granted SHALL re-set pending[i] with the new address; the granted address is the pre-edge latch content; no request is lost.
REQ-024 mem_valid received outside WAIT and mem_ack received outside ISSUE SHALL be ignored.
REQ-025 mem_ack and mem_valid in the same cycle while in ISSUE SHALL be treated as ack only; data is taken from the next mem_valid.
REQ-026 Minimum turnaround: IDLE->ISSUE->WAIT->IDLE; a new grant may start in the IDLE cycle that follows the cl_rdy pulse edge.
REQ-027 cl_data SHALL hold its last value between pulses.

Reset
REQ-028 While RESET=1: state=IDLE, all pending flags=0, address latches=0, mem_addr=0, mem_rd=0, cl_rdy=0, cl_data=0, last_owner=NCLIENTS-1.
REQ-029 RESET asserted mid-transaction SHALL abort it; a mem_valid arriving after RESET deasserts SHALL be ignored (REQ-024).
REQ-030 Requests pulsed while RESET=1 SHALL be discarded.

Verification
REQ-031 Single request: cl_req[2]=1, cl_addr[2]=0x0012340; ack after 3 cycles, mem_valid with 0xBEEF after 5 more -> mem_addr=0x0012340 while mem_rd=1; cl_rdy=0b0100 and cl_data=0xBEEF one cycle after mem_valid.
REQ-032 Simultaneous: cl_req=0b1111 in one cycle, immediate ack and valid -> grant order 0,1,2,3; four cl_rdy pulses, each returning data to the correct client.
REQ-033 Fairness: client 0 re-requests immediately after every cl_rdy, client 3 requests once -> client 3 is served no later than the second grant after its request.
REQ-034 Overwrite: client 1 pulses 0x100 then 0x200 while client 0 is in WAIT -> exactly one read for client 1, at address 0x200.
REQ-035 Same-cycle regrant: cl_req[0] with 0x300 in the cycle client 0 is granted 0x280 -> reads at 0x280, then 0x300; two cl_rdy[0] pulses.
REQ-036 Reset mid-WAIT: assert RESET during WAIT, release, then send mem_valid -> no cl_rdy pulse; all outputs at reset values; the next request is served normally.
